enc_stepper_ctrl: RTL

Clocked, parametrised rotary-encoder-to-stepper controller. It synchronises and debounces quadrature inputs Ain/Bin and the Shaft push-button, then decodes direction. Encoder motion accumulates in a saturating pending-step counter, which a rate-limited sequencer drains into half- or full-step coil patterns on `motor`. It also tracks absolute position and drives one active-low 7-segment digit showing phase (1..8) or 'H' when held.

---
 rtl/enc_stepper_ctrl_if.sv | 39 +++
 rtl/enc_stepper_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/enc_stepper_ctrl_if.sv
// rtl/enc_stepper_ctrl_if.sv - signal bundle between the encoder/stepper controller and its environment
//
// Purpose: groups encoder inputs, mode controls and coil/display/status outputs.
// Ports (signals):
//   Ain, Bin, Shaft        encoder channels and push-button (asynchronous)
//   half_step, coil_en     step mode select, coil drive enable
//   motor[3:0]             coil drive pattern
//   seg[7:0], AN[7:0]      active-low 7-segment segments / digit enables
//   position[POS_WIDTH-1:0] signed wrapping step count
//   dir, step_pulse, held, enc_err  status outputs
// Modports: master drives the inputs of the controller, slave is the controller.

interface enc_stepper_ctrl_if #(
  parameter int POS_WIDTH = 16
);
  logic                 Ain;
  logic                 Bin;
  logic                 Shaft;
  logic                 half_step;
  logic                 coil_en;
  logic [3:0]           motor;
  logic [7:0]           seg;
  logic [7:0]           AN;
  logic [POS_WIDTH-1:0] position;
  logic                 dir;
  logic                 step_pulse;
  logic                 held;
  logic                 enc_err;

  modport master (
    output Ain, Bin, Shaft, half_step, coil_en,
    input  motor, seg, AN, position, dir, step_pulse, held, enc_err
  );

  modport slave (
    input  Ain, Bin, Shaft, half_step, coil_en,
    output motor, seg, AN, position, dir, step_pulse, held, enc_err
  );
endinterface

// File: rtl/enc_stepper_ctrl.sv
// rtl/enc_stepper_ctrl.sv - rotary encoder to stepper controller with debounce, rate limit and display
//
// Purpose: synchronises and debounces Ain/Bin/Shaft, decodes quadrature motion into a
// saturating pending-step counter, drains it at one step per STEP_DIV clocks into
// half/full-step coil patterns, tracks position and drives one 7-segment digit.
// Ports:
//   clk    rising-edge system clock
//   rst_n  synchronous active-low reset
//   io     enc_stepper_ctrl_if.slave: Ain, Bin, Shaft, half_step, coil_en in;
//          motor, seg, AN, position, dir, step_pulse, held, enc_err out

module enc_stepper_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_DIV        = 50000,
  parameter int MAX_PENDING     = 15,
  parameter int POS_WIDTH       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  enc_stepper_ctrl_if.slave io
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW  = $clog2(STEP_DIV);
  localparam int PW  = $clog2(MAX_PENDING + 1) + 2;
  localparam logic [DCW-1:0]       DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]        T_LAST  = TW'(STEP_DIV - 1);
  localparam logic signed [PW-1:0] P_MAX   = PW'(MAX_PENDING);
  localparam logic signed [PW-1:0] P_MIN   = -P_MAX;

  // Input bit order everywhere: [2]=A, [1]=B, [0]=Shaft
  logic [2:0]           sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d;
  logic [2:0][DCW-1:0]  cnt_q, cnt_d;
  logic [1:0]           prev_ab_q, prev_ab_d;
  logic                 shaft_prev_q, shaft_prev_d;
  logic signed [PW-1:0] pending_q, pending_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [2:0]           idx_q, idx_d;
  logic [POS_WIDTH-1:0] position_q, position_d;
  logic                 dir_q, dir_d, held_q, held_d;
  logic                 step_pulse_q, step_pulse_d, enc_err_q, enc_err_d;
  logic [3:0]           motor_q, motor_d;
  logic [7:0]           seg_q, seg_d, an_q, an_d;

  logic [1:0] cur_pos, prev_pos, move;
  logic       enc_up, enc_dn, tick, issue, issue_cw, shaft_rise;
  logic [3:0] phase;
  logic [7:0] digit;

  // Synchroniser and per-input debounce: the count only advances while the
  // synchronised value disagrees with the accepted one, so any bounce restarts it.
  always_comb begin
    sync1_d = {io.Ain, io.Bin, io.Shaft};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DB_LAST) deb_d[i] = sync2_q[i];
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    // Gray-to-binary maps the CW cycle 00,01,11,10 onto 0,1,2,3, so the modulo-4
    // difference is 1 for CW, 3 for CCW and 2 when both bits flipped.
    cur_pos   = {deb_q[2], deb_q[2] ^ deb_q[1]};
    prev_pos  = {prev_ab_q[1], prev_ab_q[1] ^ prev_ab_q[0]};
    move      = cur_pos - prev_pos;
    enc_up    = !held_q && (move == 2'd1);
    enc_dn    = !held_q && (move == 2'd3);
    enc_err_d = (move == 2'd2);
    prev_ab_d = deb_q[2:1];

    shaft_rise   = deb_q[0] && !shaft_prev_q;
    shaft_prev_d = deb_q[0];
    held_d       = held_q ^ shaft_rise;

    tick     = (timer_q == T_LAST);
    timer_d  = tick ? '0 : timer_q + 1'b1;
    issue    = tick && (pending_q != '0) && !held_q;
    issue_cw = !pending_q[PW-1];

    pending_d = pending_q;
    if (enc_up) pending_d = pending_d + PW'(1);
    if (enc_dn) pending_d = pending_d - PW'(1);
    if (issue)  pending_d = issue_cw ? pending_d - PW'(1) : pending_d + PW'(1);
    if (pending_d > P_MAX)      pending_d = P_MAX;
    else if (pending_d < P_MIN) pending_d = P_MIN;
    if (shaft_rise && !held_q)  pending_d = '0;

    step_pulse_d = issue;
    dir_d        = dir_q;
    position_d   = position_q;
    idx_d        = idx_q;
    if (issue) begin
      dir_d      = issue_cw;
      position_d = issue_cw ? position_q + POS_WIDTH'(1) : position_q - POS_WIDTH'(1);
      // Full-step moves land on even phases, realigning after a half-step run.
      if (io.half_step) idx_d = issue_cw ? idx_q + 3'd1 : idx_q - 3'd1;
      else              idx_d = issue_cw ? (idx_q | 3'd1) + 3'd1 : (idx_q - 3'd1) & 3'b110;
    end

    case (idx_q)
      3'd0:    begin phase = 4'b0001; digit = 8'hF9; end
      3'd1:    begin phase = 4'b0011; digit = 8'hA4; end
      3'd2:    begin phase = 4'b0010; digit = 8'hB0; end
      3'd3:    begin phase = 4'b0110; digit = 8'h99; end
      3'd4:    begin phase = 4'b0100; digit = 8'h92; end
      3'd5:    begin phase = 4'b1100; digit = 8'h82; end
      3'd6:    begin phase = 4'b1000; digit = 8'hF8; end
      default: begin phase = 4'b1001; digit = 8'h80; end
    endcase
    motor_d = io.coil_en ? phase : 4'b0000;
    seg_d   = held_q ? 8'b10001001 : digit;
    an_d    = 8'b11111110;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_q        <= '0;
      cnt_q        <= '0;
      prev_ab_q    <= '0;
      shaft_prev_q <= 1'b0;
      pending_q    <= '0;
      timer_q      <= '0;
      idx_q        <= '0;
      position_q   <= '0;
      dir_q        <= 1'b1;
      held_q       <= 1'b0;
      step_pulse_q <= 1'b0;
      enc_err_q    <= 1'b0;
      motor_q      <= 4'b0000;
      seg_q        <= 8'hFF;
      an_q         <= 8'hFF;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      deb_q        <= deb_d;
      cnt_q        <= cnt_d;
      prev_ab_q    <= prev_ab_d;
      shaft_prev_q <= shaft_prev_d;
      pending_q    <= pending_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      position_q   <= position_d;
      dir_q        <= dir_d;
      held_q       <= held_d;
      step_pulse_q <= step_pulse_d;
      enc_err_q    <= enc_err_d;
      motor_q      <= motor_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign io.motor      = motor_q;
  assign io.seg        = seg_q;
  assign io.AN         = an_q;
  assign io.position   = position_q;
  assign io.dir        = dir_q;
  assign io.step_pulse = step_pulse_q;
  assign io.held       = held_q;
  assign io.enc_err    = enc_err_q;

endmodule
